ct_ciu_regs_hpcp_resp: RTL and testbench



---
 rtl/ct_ciu_regs_hpcp_resp.sv | 139 +++++++++++++
 tb/tb_ct_ciu_regs_hpcp_resp.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ct_ciu_regs_hpcp_resp.sv
// CIU responder for the PIU register channel: four L2 performance counters,
// their overflow status and interrupt enables, with a 2-cycle request/completion protocol.
module ct_ciu_regs_hpcp_resp #(
  parameter int unsigned CNT_WIDTH = 48,
  parameter int unsigned NUM_CNT   = 4
) (
  input  logic                 forever_cpuclk,
  input  logic                 cpurst_b,
  input  logic                 piu_regs_sel,
  input  logic [15:0]          piu_regs_op,
  input  logic [63:0]          piu_regs_wdata,
  input  logic [NUM_CNT-1:0]   piu_regs_hpcp_cnt_en,
  input  logic [NUM_CNT-1:0]   l2c_hpcp_evt,
  output logic                 regs_piu_cmplt,
  output logic [63:0]          regs_piux_rdata,
  output logic [NUM_CNT-1:0]   regs_piu_hpcp_l2of_int,
  output logic                 regs_piu_proto_err
);

  localparam logic [11:0] AddrOvf   = 12'h010;
  localparam logic [11:0] AddrInten = 12'h011;

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e                 state_q, state_d;
  logic                   capture;
  logic [11:0]            addr_q;
  logic                   wr_q;
  logic [CNT_WIDTH-1:0]   wdata_q;
  logic [CNT_WIDTH-1:0]   cnt_q [NUM_CNT];
  logic [CNT_WIDTH-1:0]   cnt_d [NUM_CNT];
  logic [NUM_CNT-1:0]     ovf_q, ovf_d, ovf_set, ovf_w1c;
  logic [NUM_CNT-1:0]     inten_q, inten_d;
  logic [NUM_CNT-1:0]     int_q;
  logic                   cmplt_q;
  logic [63:0]            rdata_q, rd_data;
  logic                   err_q;
  logic                   acc, is_cnt;
  logic [1:0]             cnt_idx;
  logic                   unused_bits;

  assign unused_bits = ^{piu_regs_op[14:12], piu_regs_wdata};

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (piu_regs_sel) begin
          capture = 1'b1;
          state_d = StAccess;
        end
      end
      StAccess: state_d = StResp;
      StResp: begin
        if (piu_regs_sel) begin
          capture = 1'b1;
          state_d = StAccess;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign acc     = (state_q == StAccess);
  assign is_cnt  = (addr_q[11:2] == 10'd0);
  assign cnt_idx = addr_q[1:0];

  always_comb begin
    ovf_set = '0;
    ovf_w1c = '0;
    inten_d = inten_q;
    rd_data = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      cnt_d[i] = cnt_q[i];
      // A software write overrides a same-cycle increment and suppresses its overflow.
      if (acc && wr_q && is_cnt && (cnt_idx == 2'(i))) begin
        cnt_d[i] = wdata_q;
      end else if (piu_regs_hpcp_cnt_en[i] && l2c_hpcp_evt[i]) begin
        cnt_d[i]   = cnt_q[i] + CNT_WIDTH'(1);
        ovf_set[i] = &cnt_q[i];
      end
    end
    if (acc && wr_q && (addr_q == AddrOvf)) begin
      ovf_w1c = wdata_q[NUM_CNT-1:0];
    end
    if (acc && wr_q && (addr_q == AddrInten)) begin
      inten_d = wdata_q[NUM_CNT-1:0];
    end
    if (!wr_q) begin
      if (is_cnt) begin
        rd_data[CNT_WIDTH-1:0] = cnt_q[cnt_idx];
      end else if (addr_q == AddrOvf) begin
        rd_data[NUM_CNT-1:0] = ovf_q;
      end else if (addr_q == AddrInten) begin
        rd_data[NUM_CNT-1:0] = inten_q;
      end
    end
    ovf_d = (ovf_q & ~ovf_w1c) | ovf_set;
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q <= StIdle;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      for (int i = 0; i < NUM_CNT; i++) cnt_q[i] <= '0;
      ovf_q   <= '0;
      inten_q <= '0;
      int_q   <= '0;
      cmplt_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        addr_q  <= piu_regs_op[11:0];
        wr_q    <= piu_regs_op[15];
        wdata_q <= piu_regs_wdata[CNT_WIDTH-1:0];
      end
      for (int i = 0; i < NUM_CNT; i++) cnt_q[i] <= cnt_d[i];
      ovf_q   <= ovf_d;
      inten_q <= inten_d;
      int_q   <= ovf_d & inten_d;
      cmplt_q <= acc;
      rdata_q <= acc ? rd_data : 64'd0;
      if (acc && piu_regs_sel) err_q <= 1'b1;
    end
  end

  assign regs_piu_cmplt         = cmplt_q;
  assign regs_piux_rdata        = rdata_q;
  assign regs_piu_hpcp_l2of_int = int_q;
  assign regs_piu_proto_err     = err_q;

endmodule

// File: tb/tb_ct_ciu_regs_hpcp_resp.sv
// Scoreboard bench for ct_ciu_regs_hpcp_resp: expected completions are queued at issue time
// and matched (data and cycle) when cmplt is observed.
module tb_ct_ciu_regs_hpcp_resp;

  logic        clk;
  logic        rst_n;
  logic        sel;
  logic [15:0] op;
  logic [63:0] wdata;
  logic [3:0]  cnt_en;
  logic [3:0]  evt;
  logic        cmplt;
  logic [63:0] rdata;
  logic [3:0]  l2of_int;
  logic        proto_err;

  typedef struct {
    logic [63:0] rd;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc;
  int   n_tests;
  int   n_fail;

  ct_ciu_regs_hpcp_resp #(
    .CNT_WIDTH (48),
    .NUM_CNT   (4)
  ) dut (
    .forever_cpuclk         (clk),
    .cpurst_b               (rst_n),
    .piu_regs_sel           (sel),
    .piu_regs_op            (op),
    .piu_regs_wdata         (wdata),
    .piu_regs_hpcp_cnt_en   (cnt_en),
    .l2c_hpcp_evt           (evt),
    .regs_piu_cmplt         (cmplt),
    .regs_piux_rdata        (rdata),
    .regs_piu_hpcp_l2of_int (l2of_int),
    .regs_piu_proto_err     (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Issue one request; acc_evt pulses cnt_en/evt only during the ACCESS cycle.
  task automatic req(input logic [15:0] o, input logic [63:0] wd, input logic [63:0] exp,
                     input logic [3:0] acc_evt);
    exp_t e;
    sel   = 1'b1;
    op    = o;
    wdata = wd;
    e.rd  = exp;
    e.cyc = cyc + 2;
    sb.push_back(e);
    @(posedge clk); #1;
    sel    = 1'b0;
    op     = '0;
    wdata  = '0;
    cnt_en = acc_evt;
    evt    = acc_evt;
    @(posedge clk); #1;
    cnt_en = '0;
    evt    = '0;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (cmplt) begin
        if (sb.size() == 0) begin
          check("unexpected_cmplt", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check("rdata", rdata, e.rd);
          check("cmplt_cycle", 64'(cyc), 64'(e.cyc));
        end
      end else begin
        check("rdata_idle_zero", rdata, 64'd0);
      end
    end
  end

  initial begin
    exp_t e;
    n_tests = 0;
    n_fail  = 0;
    sel     = 1'b0;
    op      = '0;
    wdata   = '0;
    cnt_en  = '0;
    evt     = '0;
    rst_n   = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmplt", 64'(cmplt), 64'd0);
    check("rst_rdata", rdata, 64'd0);
    check("rst_int", 64'(l2of_int), 64'd0);
    check("rst_err", 64'(proto_err), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // INTEN write then readback, back to back
    req(16'h8011, 64'hF, 64'd0, 4'h0);
    req(16'h0011, 64'd0, 64'hF, 4'h0);
    check("int_no_ovf", 64'(l2of_int), 64'd0);

    // Counter 0 wrap over two event cycles
    req(16'h8000, 64'h0000_FFFF_FFFF_FFFE, 64'd0, 4'h0);
    cnt_en = 4'h1;
    evt    = 4'h1;
    repeat (2) @(posedge clk);
    #1;
    cnt_en = '0;
    evt    = '0;
    check("int_after_wrap0", 64'(l2of_int), 64'h1);
    req(16'h0000, 64'd0, 64'd0, 4'h0);
    req(16'h0010, 64'd0, 64'h1, 4'h0);
    req(16'h8010, 64'h1, 64'd0, 4'h0);
    check("int_after_w1c0", 64'(l2of_int), 64'd0);
    req(16'h0010, 64'd0, 64'd0, 4'h0);

    // Counter 2 wrap coincident with W1C of OVF[2]: set wins
    req(16'h8002, 64'h0000_FFFF_FFFF_FFFF, 64'd0, 4'h0);
    req(16'h0002, 64'd0, 64'h0000_FFFF_FFFF_FFFF, 4'h0);
    req(16'h8010, 64'h4, 64'd0, 4'h4);
    check("int_set_wins", 64'(l2of_int), 64'h4);
    req(16'h0010, 64'd0, 64'h4, 4'h0);
    req(16'h8010, 64'h4, 64'd0, 4'h0);
    check("int_w1c2", 64'(l2of_int), 64'd0);
    req(16'h0010, 64'd0, 64'd0, 4'h0);
    req(16'h0002, 64'd0, 64'd0, 4'h0);

    // Software write beats a same-cycle increment on an all-ones counter
    req(16'h8003, 64'h0000_FFFF_FFFF_FFFF, 64'd0, 4'h0);
    req(16'h8003, 64'h5, 64'd0, 4'h8);
    req(16'h0003, 64'd0, 64'h5, 4'h0);
    req(16'h0010, 64'd0, 64'd0, 4'h0);

    // sel on three consecutive cycles: middle one dropped
    check("err_before", 64'(proto_err), 64'd0);
    sel   = 1'b1;
    op    = 16'h0011;
    e.rd  = 64'hF;
    e.cyc = cyc + 2;
    sb.push_back(e);
    @(posedge clk); #1;
    op    = 16'h8011;
    wdata = 64'd0;
    @(posedge clk); #1;
    check("err_set", 64'(proto_err), 64'd1);
    op    = 16'h0003;
    e.rd  = 64'h5;
    e.cyc = cyc + 2;
    sb.push_back(e);
    @(posedge clk); #1;
    sel = 1'b0;
    op  = '0;
    @(posedge clk); #1;
    req(16'h0011, 64'd0, 64'hF, 4'h0);

    // Undefined addresses and ignored reserved op bits
    req(16'h0123, 64'd0, 64'd0, 4'h0);
    req(16'h8123, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 4'h0);
    req(16'h7011, 64'd0, 64'hF, 4'h0);
    req(16'h0010, 64'd0, 64'd0, 4'h0);
    req(16'h0003, 64'd0, 64'h5, 4'h0);
    req(16'h0000, 64'd0, 64'd0, 4'h0);
    check("err_sticky", 64'(proto_err), 64'd1);

    // Reset during the ACCESS cycle of a counter 1 write
    req(16'h8001, 64'h55, 64'd0, 4'h0);
    req(16'h0001, 64'd0, 64'h55, 4'h0);
    sel   = 1'b1;
    op    = 16'h8001;
    wdata = 64'h1234;
    @(posedge clk); #1;
    sel   = 1'b0;
    op    = '0;
    wdata = '0;
    rst_n = 1'b0;
    #1;
    check("midrst_cmplt", 64'(cmplt), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("midrst_err", 64'(proto_err), 64'd0);
    check("midrst_int", 64'(l2of_int), 64'd0);
    @(posedge clk); #1;
    req(16'h0001, 64'd0, 64'd0, 4'h0);
    req(16'h0011, 64'd0, 64'd0, 4'h0);

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
